// File: rtl/sfq_delay_rx.sv
// sfq_delay_rx: far-end checker for an SFQ transmission path.
// Decodes the toggle-encoded launch and arrive lines into pulses and keeps
// launch timestamps in a small circular FIFO. Arrivals are matched to launches
// in order, and the launch-to-arrival delay is reported in clk cycles. Sticky
// flags record early, late, spurious and overflow conditions.
module sfq_delay_rx #(
  parameter int TS_W    = 8,
  parameter int DEPTH   = 4,
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 10,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   launch,
  input  logic                   arrive,
  output logic                   delay_valid,
  output logic [TS_W-1:0]        last_delay,
  output logic [CNT_W-1:0]       meas_cnt,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_early,
  output logic                   err_late,
  output logic                   err_spurious,
  output logic                   err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  // Delay bounds and FIFO capacity, sized to the signals they are compared with.
  localparam logic [TS_W-1:0]  MIN_TS     = TS_W'(MIN_DLY);
  localparam logic [TS_W-1:0]  MAX_TS     = TS_W'(MAX_DLY);
  localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam bit               ZERO_EARLY = (MIN_DLY > 0);

  logic             launch_q;
  logic             arrive_q;
  logic             ev_l;
  logic             ev_a;
  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [TS_W-1:0]  head;
  logic [TS_W-1:0]  age;
  logic             empty;
  logic             full;
  logic             do_match;
  logic             do_zero;
  logic             do_spur;
  logic             do_late;
  logic             do_pop;
  logic             push_req;
  logic             do_push;
  logic             do_ovf;

  // Pulse detection, head age and the per-cycle decision of what to pop/push.
  // An arrival always wins over a timeout, so at most one pop happens per cycle.
  // A simultaneous launch+arrival on an empty FIFO is a zero delay and pushes nothing.
  always_comb begin
    ev_l     = launch ^ launch_q;
    ev_a     = arrive ^ arrive_q;
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    head     = mem[rd_ptr];
    age      = ts - head;
    do_match = ev_a && !empty;
    do_zero  = ev_a && empty && ev_l;
    do_spur  = ev_a && empty && !ev_l;
    do_late  = !ev_a && !empty && (age > MAX_TS);
    do_pop   = do_match || do_late;
    push_req = ev_l && !do_zero;
    do_push  = push_req && (!full || do_pop);
    do_ovf   = push_req && full && !do_pop;
  end

  // Timestamp storage; entries need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= ts;
    end
  end

  // Line samples, timestamp, FIFO pointers, measurement results and sticky flags.
  // The samples load the live line levels even in reset, so a line held high
  // through reset does not look like a pulse afterwards.
  always_ff @(posedge clk) begin
    launch_q <= launch;
    arrive_q <= arrive;
    if (rst) begin
      ts           <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      delay_valid  <= 1'b0;
      last_delay   <= '0;
      meas_cnt     <= '0;
      err_early    <= 1'b0;
      err_late     <= 1'b0;
      err_spurious <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      ts          <= ts + 1'b1;
      delay_valid <= do_match || do_zero;

      if (do_match) begin
        last_delay <= age;
        if (age < MIN_TS) begin
          err_early <= 1'b1;
        end
      end

      if (do_zero) begin
        last_delay <= '0;
        if (ZERO_EARLY) begin
          err_early <= 1'b1;
        end
      end

      if ((do_match || do_zero) && (meas_cnt != '1)) begin
        meas_cnt <= meas_cnt + 1'b1;
      end

      if (do_spur) begin
        err_spurious <= 1'b1;
      end
      if (do_late) begin
        err_late <= 1'b1;
      end
      if (do_ovf) begin
        err_overflow <= 1'b1;
      end

      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign outstanding = count;

endmodule

// File: tb/tb_sfq_delay_rx.sv
// tb_sfq_delay_rx: bench for sfq_delay_rx. The reference model keeps absolute
// launch cycle numbers in a queue, and it works out delays as plain differences.
module tb_sfq_delay_rx;

  localparam int TS_W    = 8;
  localparam int DEPTH   = 4;
  localparam int MIN_DLY = 2;
  localparam int MAX_DLY = 10;
  localparam int CNT_W   = 16;
  localparam int OUT_W   = $clog2(DEPTH) + 1;

  typedef struct {
    int       idle;
    bit       l_tog;
    bit       a_tog;
    bit       dv;
    int       last;
    int       outst;
    int       cnt;
    bit [3:0] errs;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             launch;
  logic             arrive;
  logic             delay_valid;
  logic [TS_W-1:0]  last_delay;
  logic [CNT_W-1:0] meas_cnt;
  logic [OUT_W-1:0] outstanding;
  logic             err_early;
  logic             err_late;
  logic             err_spurious;
  logic             err_overflow;

  int checks   = 0;
  int failures = 0;

  int m_cyc;
  int m_pend[$];
  bit m_dv;
  int m_last;
  int m_cnt;
  bit m_early;
  bit m_late;
  bit m_spur;
  bit m_ovf;

  vec_t vecs[7];

  sfq_delay_rx #(
    .TS_W(TS_W), .DEPTH(DEPTH), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .launch(launch),
    .arrive(arrive),
    .delay_valid(delay_valid),
    .last_delay(last_delay),
    .meas_cnt(meas_cnt),
    .outstanding(outstanding),
    .err_early(err_early),
    .err_late(err_late),
    .err_spurious(err_spurious),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_pend.delete();
    m_dv    = 1'b0;
    m_last  = 0;
    m_cnt   = 0;
    m_early = 1'b0;
    m_late  = 1'b0;
    m_spur  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic bump_count();
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endtask

  // The model handles one clock edge that sees a launch pulse (el) and/or an arrival pulse (ea).
  task automatic model_edge(input bit el, input bit ea);
    bit was_empty;
    bit zero_hit;
    was_empty = (m_pend.size() == 0);
    zero_hit  = 1'b0;
    m_dv      = 1'b0;
    if (ea) begin
      if (!was_empty) begin
        m_last = m_cyc - m_pend.pop_front();
        m_dv   = 1'b1;
        bump_count();
        if (m_last < MIN_DLY) m_early = 1'b1;
      end else if (el) begin
        m_last   = 0;
        m_dv     = 1'b1;
        zero_hit = 1'b1;
        bump_count();
        if (MIN_DLY > 0) m_early = 1'b1;
      end else begin
        m_spur = 1'b1;
      end
    end else if (!was_empty && (m_cyc - m_pend[0]) > MAX_DLY) begin
      void'(m_pend.pop_front());
      m_late = 1'b1;
    end
    if (el && !zero_hit) begin
      if (m_pend.size() < DEPTH) m_pend.push_back(m_cyc);
      else m_ovf = 1'b1;
    end
    m_cyc++;
  endtask

  task automatic check_model();
    checkOutput("model_dv", 32'(delay_valid), 32'(m_dv));
    checkOutput("model_last_delay", 32'(last_delay), m_last);
    checkOutput("model_meas_cnt", 32'(meas_cnt), m_cnt);
    checkOutput("model_outstanding", 32'(outstanding), m_pend.size());
    checkOutput("model_errs", 32'({err_early, err_late, err_spurious, err_overflow}),
                32'({m_early, m_late, m_spur, m_ovf}));
  endtask

  // Inputs change 1 time unit after a rising edge, and outputs are sampled 1 time unit after the next rising edge.
  task automatic applyStimulus(input bit l_tog, input bit a_tog);
    launch = launch ^ l_tog;
    arrive = arrive ^ a_tog;
    model_edge(l_tog, a_tog);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic l_lvl, input logic a_lvl);
    rst    = 1'b1;
    launch = l_lvl;
    arrive = a_lvl;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Each table row gives {idle cycles, launch toggle, arrive toggle, dv, last, outstanding, cnt, {early,late,spur,ovf}}.
    vecs[0] = '{5, 1'b1, 1'b0, 1'b0, 0, 1, 0, 4'b0000};
    vecs[1] = '{4, 1'b0, 1'b1, 1'b1, 5, 0, 1, 4'b0000};
    vecs[2] = '{0, 1'b0, 1'b0, 1'b0, 5, 0, 1, 4'b0000};
    vecs[3] = '{0, 1'b1, 1'b0, 1'b0, 5, 1, 1, 4'b0000};
    vecs[4] = '{0, 1'b0, 1'b1, 1'b1, 1, 0, 2, 4'b1000};
    vecs[5] = '{0, 1'b1, 1'b1, 1'b1, 0, 0, 3, 4'b1000};
    vecs[6] = '{0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 4'b1000};

    do_reset(1'b0, 1'b0);
    checkOutput("reset_outstanding", 32'(outstanding), 0);
    checkOutput("reset_errs", 32'({err_early, err_late, err_spurious, err_overflow}), 0);

    // Nominal, early and simultaneous cases
    for (int i = 0; i < 7; i++) begin
      repeat (vecs[i].idle) applyStimulus(1'b0, 1'b0);
      applyStimulus(vecs[i].l_tog, vecs[i].a_tog);
      checkOutput($sformatf("vec%0d_dv", i), 32'(delay_valid), 32'(vecs[i].dv));
      checkOutput($sformatf("vec%0d_last", i), 32'(last_delay), vecs[i].last);
      checkOutput($sformatf("vec%0d_outst", i), 32'(outstanding), vecs[i].outst);
      checkOutput($sformatf("vec%0d_cnt", i), 32'(meas_cnt), vecs[i].cnt);
      checkOutput($sformatf("vec%0d_errs", i),
                  32'({err_early, err_late, err_spurious, err_overflow}), 32'(vecs[i].errs));
    end

    // Timeout: a launch aged past MAX_DLY is dropped at age 11, and a later arrival is spurious
    do_reset(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("late_hold_outst", 32'(outstanding), 1);
    checkOutput("late_hold_flag", 32'(err_late), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("late_pop_outst", 32'(outstanding), 0);
    checkOutput("late_pop_flag", 32'(err_late), 1);
    checkOutput("late_pop_dv", 32'(delay_valid), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("late_spurious", 32'(err_spurious), 1);
    checkOutput("late_cnt", 32'(meas_cnt), 0);

    // Overflow: five launches back to back, then five arrivals
    do_reset(1'b0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0);
    checkOutput("ovf_flag", 32'(err_overflow), 1);
    checkOutput("ovf_outst", 32'(outstanding), DEPTH);
    repeat (5) applyStimulus(1'b0, 1'b1);
    checkOutput("ovf_last", 32'(last_delay), 5);
    checkOutput("ovf_cnt", 32'(meas_cnt), 4);
    checkOutput("ovf_spurious", 32'(err_spurious), 1);
    checkOutput("ovf_outst_end", 32'(outstanding), 0);

    // Full FIFO with a push and a pop in the same cycle
    do_reset(1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("full_outst", 32'(outstanding), DEPTH);
    applyStimulus(1'b1, 1'b1);
    checkOutput("pushpop_outst", 32'(outstanding), DEPTH);
    checkOutput("pushpop_ovf", 32'(err_overflow), 0);
    checkOutput("pushpop_dv", 32'(delay_valid), 1);
    checkOutput("pushpop_last", 32'(last_delay), 4);

    // Launch line held high through reset gives no pulse
    do_reset(1'b0, 1'b0);
    do_reset(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("hold_outst", 32'(outstanding), 0);
    checkOutput("hold_errs", 32'({err_early, err_late, err_spurious, err_overflow}), 0);

    // Timestamp wrap: launch at ts=254 and arrival at ts=3
    do_reset(1'b0, 1'b0);
    repeat (254) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wrap_dv", 32'(delay_valid), 1);
    checkOutput("wrap_last", 32'(last_delay), 5);
    checkOutput("wrap_late", 32'(err_late), 0);

    // Reset while three launches are still outstanding
    applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_pre_outst", 32'(outstanding), 3);
    checkOutput("midrst_pre_spur", 32'(err_spurious), 1);
    do_reset(launch, arrive);
    checkOutput("midrst_outst", 32'(outstanding), 0);
    checkOutput("midrst_errs", 32'({err_early, err_late, err_spurious, err_overflow}), 0);
    checkOutput("midrst_cnt", 32'(meas_cnt), 0);
    checkOutput("midrst_last", 32'(last_delay), 0);

    // Random traffic with occasional resets
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
